// File: rtl/pkt_pkg.sv
// Shared definitions for the packet feeder that sits in front of q_server:
// default widths/delays and the feeder FSM state encoding.
package pkt_pkg;

    localparam int LEN_W_DEF   = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int RDY_DLY_DEF = 2;

    // Feeder FSM states, fixed 3-bit encoding
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        ARM      = 3'd2,
        SEND     = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/pkt_desc_fifo.sv
// Small synchronous descriptor FIFO for pkt_feeder.
// Exposes the head entry and the entry behind it, so the feeder can pop the
// finished packet and load the following length in the same cycle.
// The full flag is registered, so in_ready upstream comes straight off a flop.
module pkt_desc_fifo
    import pkt_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [LEN_W-1:0]           push_data,
    input  logic                       pop,
    output logic [LEN_W-1:0]           head_data,
    output logic [LEN_W-1:0]           next_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LEN_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nx;
    logic [CW-1:0]    count_nx;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses a push even when a pop happens in the same cycle
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign rd_ptr_nx = rd_ptr + AW'(1);
    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr_nx];
    assign empty     = (count == '0);

    // Next occupancy from accepted push and pop
    always_comb begin
        count_nx = count + CW'(push_ok) - CW'(pop_ok);
    end

    // Storage array, written only on an accepted push; no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH; the occupancy counter separates full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_nx;
            end
            count <= count_nx;
            full  <= (count_nx == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/pkt_feeder.sv
// Upstream feeder for q_server: queues packet-length descriptors, presents the
// head length on pkt_len, arms the server through ena_n a fixed delay after it
// reports ready, and counts the length down while the server transmits.
// Optional build macro PKT_FEEDER_STATS_EN adds packet/unit statistics outputs.
module pkt_feeder
    import pkt_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int RDY_DLY = RDY_DLY_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [LEN_W-1:0]        in_len,
    output logic                    in_ready,
    output logic                    zero_drop,
    output logic [LEN_W-1:0]        pkt_len,
    output logic                    ena_n,
    input  logic                    bool_ready,
    input  logic                    bool_go,
    output logic                    busy,
`ifdef PKT_FEEDER_STATS_EN
    output logic [15:0]             pkt_done_cnt,
    output logic [31:0]             unit_cnt,
`endif
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int DLY_W = 3;

    state_t             state_q;
    state_t             state_d;
    logic [LEN_W-1:0]   len_d;
    logic [DLY_W-1:0]   dly_q;
    logic [DLY_W-1:0]   dly_d;
    logic               pop;
    logic               dec;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LEN_W-1:0]   head_data;
    logic [LEN_W-1:0]   next_data;

    // Zero-length descriptors are never stored
    assign push     = in_valid && (in_len != '0);
    assign in_ready = !fifo_full;

    pkt_desc_fifo #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_len),
        .pop       (pop),
        .head_data (head_data),
        .next_data (next_data),
        .count     (q_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state, length and arm-delay decisions for the packet FSM
    always_comb begin
        state_d = state_q;
        len_d   = pkt_len;
        dly_d   = dly_q;
        pop     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    len_d   = head_data;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (bool_ready) begin
                    dly_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!bool_ready) begin
                    state_d = WAIT_RDY;
                end else if (dly_q == DLY_W'(RDY_DLY)) begin
                    state_d = SEND;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            SEND: begin
                if (bool_go && (pkt_len != '0)) begin
                    dec   = 1'b1;
                    len_d = pkt_len - LEN_W'(1);
                    if (pkt_len == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bool_go) begin
                    pop = 1'b1;
                    if (q_count > CW'(1)) begin
                        len_d   = next_data;
                        state_d = WAIT_RDY;
                    end else begin
                        len_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, length, delay counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pkt_len   <= '0;
            dly_q     <= '0;
            ena_n     <= 1'b1;
            busy      <= 1'b0;
            zero_drop <= 1'b0;
        end else begin
            state_q   <= state_d;
            pkt_len   <= len_d;
            dly_q     <= dly_d;
            ena_n     <= (state_d != SEND);
            busy      <= (state_d != IDLE);
            zero_drop <= in_valid && in_ready && (in_len == '0);
        end
    end

`ifdef PKT_FEEDER_STATS_EN
    // Saturating count of completed packets
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_done_cnt <= '0;
        end else if (pop && (pkt_done_cnt != '1)) begin
            pkt_done_cnt <= pkt_done_cnt + 16'd1;
        end
    end

    // Saturating count of transmitted units
    always_ff @(posedge clk) begin
        if (rst) begin
            unit_cnt <= '0;
        end else if (dec && (unit_cnt != '1)) begin
            unit_cnt <= unit_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_feeder.sv
// Directed testbench for pkt_feeder (DEPTH=4, LEN_W=8, RDY_DLY=2).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_pkt_feeder;
    import pkt_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_len;
    logic       in_ready;
    logic       zero_drop;
    logic [7:0] pkt_len;
    logic       ena_n;
    logic       bool_ready;
    logic       bool_go;
    logic       busy;
    logic [2:0] q_count;
`ifdef PKT_FEEDER_STATS_EN
    logic [15:0] pkt_done_cnt;
    logic [31:0] unit_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pkt_feeder #(
        .DEPTH   (4),
        .LEN_W   (8),
        .RDY_DLY (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_len       (in_len),
        .in_ready     (in_ready),
        .zero_drop    (zero_drop),
        .pkt_len      (pkt_len),
        .ena_n        (ena_n),
        .bool_ready   (bool_ready),
        .bool_go      (bool_go),
        .busy         (busy),
`ifdef PKT_FEEDER_STATS_EN
        .pkt_done_cnt (pkt_done_cnt),
        .unit_cnt     (unit_cnt),
`endif
        .q_count      (q_count)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Advance one cycle and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and reports a failure with tag and values
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One push (or zero-length attempt) over one clock edge
    task automatic applyStimulus(input logic [7:0] len);
        in_valid = 1'b1;
        in_len   = len;
        tick();
        in_valid = 1'b0;
        in_len   = 8'd0;
    endtask

    // Serve the loaded packet starting in WAIT_RDY: arm delay, countdown,
    // DONE hold, then pop (optionally with a simultaneous push)
    task automatic servePacket(input int len, input int exp_q, input int exp_next,
                               input logic push_v, input logic [7:0] push_l);
        bool_ready = 1'b1;
        bool_go    = 1'b1;
        tick();
        checkOutput("arm_ena_n_0", ena_n, 1);
        tick();
        checkOutput("arm_ena_n_1", ena_n, 1);
        tick();
        checkOutput("arm_ena_n_2", ena_n, 1);
        tick();
        checkOutput("send_ena_n", ena_n, 0);
        checkOutput("send_len", pkt_len, len);
        for (int i = 1; i <= len; i++) begin
            tick();
            checkOutput("count_down", pkt_len, len - i);
        end
        checkOutput("done_ena_n", ena_n, 1);
        tick();
        checkOutput("done_hold_busy", busy, 1);
        checkOutput("done_hold_q", q_count, exp_q + 1);
        bool_go  = 1'b0;
        in_valid = push_v;
        in_len   = push_l;
        tick();
        in_valid = 1'b0;
        in_len   = 8'd0;
        bool_ready = 1'b0;
        checkOutput("pop_q", q_count, exp_q);
        checkOutput("pop_next_len", pkt_len, exp_next);
        checkOutput("pop_busy", busy, (exp_next != 0) ? 1 : 0);
        checkOutput("pop_in_ready", in_ready, 1);
    endtask

    // Directed sequence
    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_len     = 8'd0;
        bool_ready = 1'b0;
        bool_go    = 1'b0;

        // Reset values
        tick();
        tick();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_zero_drop", zero_drop, 0);
        checkOutput("rst_pkt_len", pkt_len, 0);
        checkOutput("rst_ena_n", ena_n, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_q_count", q_count, 0);
        rst = 1'b0;

        // Single packet of 4: load one cycle after the push, then full serve
        applyStimulus(8'd4);
        checkOutput("t1_q_after_push", q_count, 1);
        checkOutput("t1_busy_after_push", busy, 0);
        tick();
        checkOutput("t1_loaded_len", pkt_len, 4);
        checkOutput("t1_loaded_busy", busy, 1);
        servePacket(4, 0, 0, 1'b0, 8'd0);

        // Zero-length push is dropped with a one-cycle pulse
        applyStimulus(8'd0);
        checkOutput("t3_zero_drop", zero_drop, 1);
        checkOutput("t3_q", q_count, 0);
        tick();
        checkOutput("t3_zero_drop_end", zero_drop, 0);
        checkOutput("t3_busy", busy, 0);
        checkOutput("t3_ena_n", ena_n, 1);

        // Back-to-back fill to full, then in-order service
        applyStimulus(8'd4);
        applyStimulus(8'd16);
        applyStimulus(8'd4);
        applyStimulus(8'd2);
        checkOutput("t2_full_in_ready", in_ready, 0);
        checkOutput("t2_full_q", q_count, 4);
        checkOutput("t2_head_len", pkt_len, 4);
        servePacket(4, 3, 16, 1'b0, 8'd0);
        servePacket(16, 2, 4, 1'b0, 8'd0);
        servePacket(4, 1, 2, 1'b0, 8'd0);
        servePacket(2, 0, 0, 1'b0, 8'd0);

        // bool_ready drops after one ARM cycle: back to WAIT_RDY, no enable
        applyStimulus(8'd5);
        tick();
        checkOutput("t4_loaded_len", pkt_len, 5);
        bool_ready = 1'b1;
        tick();
        bool_ready = 1'b0;
        tick();
        checkOutput("t4_abort_ena_n", ena_n, 1);
        tick();
        checkOutput("t4_wait_ena_n", ena_n, 1);
        checkOutput("t4_wait_busy", busy, 1);
        checkOutput("t4_wait_len", pkt_len, 5);
        servePacket(5, 0, 0, 1'b0, 8'd0);

        // Full FIFO with a push of 7 in the pop cycle: push refused
        applyStimulus(8'd3);
        applyStimulus(8'd1);
        applyStimulus(8'd1);
        applyStimulus(8'd1);
        checkOutput("t5_full_q", q_count, 4);
        checkOutput("t5_full_in_ready", in_ready, 0);
        servePacket(3, 3, 1, 1'b1, 8'd7);
        servePacket(1, 2, 1, 1'b0, 8'd0);
        servePacket(1, 1, 1, 1'b0, 8'd0);
        servePacket(1, 0, 0, 1'b0, 8'd0);

`ifdef PKT_FEEDER_STATS_EN
        checkOutput("stats_pkts", pkt_done_cnt, 10);
        checkOutput("stats_units", unit_cnt, 41);
`endif

        // Reset mid-SEND with 9 loaded and two more queued
        applyStimulus(8'd9);
        applyStimulus(8'd1);
        applyStimulus(8'd1);
        checkOutput("t6_q", q_count, 3);
        checkOutput("t6_len", pkt_len, 9);
        bool_ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checkOutput("t6_send_ena_n", ena_n, 0);
        checkOutput("t6_send_len", pkt_len, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bool_ready = 1'b0;
        checkOutput("t6_rst_len", pkt_len, 0);
        checkOutput("t6_rst_ena_n", ena_n, 1);
        checkOutput("t6_rst_q", q_count, 0);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_in_ready", in_ready, 1);
`ifdef PKT_FEEDER_STATS_EN
        checkOutput("t6_rst_pkts", pkt_done_cnt, 0);
        checkOutput("t6_rst_units", unit_cnt, 0);
`endif
        tick();
        checkOutput("t6_after_busy", busy, 0);
        checkOutput("t6_after_len", pkt_len, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
